// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Types and helpers shared by the FP cluster units.
//   round_mode_e : per-operation rounding mode, encoded as on the ALU bus
//   fp_class_e   : operand format class used to steer result selection
//   fp_bias()    : exponent bias for a given exponent field width
// ---------------------------------------------------------------------------
package fp_pkg;

   typedef enum logic [1:0] {
      FLOOR = 2'b00,
      CEIL  = 2'b01,
      TRUNC = 2'b10,
      RNE   = 2'b11
   } round_mode_e;

   typedef enum logic [2:0] {
      SPECIAL  = 3'd0,
      ZERO     = 3'd1,
      SUB_ONE  = 3'd2,
      FRAC     = 3'd3,
      INTEGRAL = 3'd4
   } fp_class_e;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_round_decode.sv
// ---------------------------------------------------------------------------
// fp_round_decode
// Combinational front end of the rounding pipe. Classifies the operand,
// builds the mask of fraction bits that must be cleared, and decides whether
// the kept magnitude has to be bumped by one integral unit.
// Ports:
//   data_i   : operand {sign, exp, man}
//   mode_i   : rounding mode (fp_pkg::round_mode_e encoding)
//   class_o  : fp_pkg::fp_class_e encoding of the operand
//   mask_o   : ones over the fraction bits (FRAC class only, else zero)
//   inc_o    : round away from the kept value (for SUB_ONE: result is 1.0)
// ---------------------------------------------------------------------------
module fp_round_decode #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 15
) (
   input  logic [EXP_W+MAN_W:0]   data_i,
   input  logic [1:0]             mode_i,
   output logic [2:0]             class_o,
   output logic [EXP_W+MAN_W-1:0] mask_o,
   output logic                   inc_o
);

   import fp_pkg::*;

   localparam int W = EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] BIAS_E   = EXP_W'(fp_bias(EXP_W));
   localparam logic [EXP_W-1:0] INT_E    = EXP_W'(fp_bias(EXP_W) + MAN_W);
   localparam logic [EXP_W-1:0] HALF_E   = EXP_W'(fp_bias(EXP_W) - 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   logic             sign;
   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man;
   logic [W-1:0]     mag;
   logic [EXP_W-1:0] f_amt;
   logic [W-1:0]     mask;
   logic             frac_nz;
   logic             round_bit;
   logic             sticky;
   logic             kept_lsb;
   fp_class_e        cls;
   round_mode_e      mode;

   // Field split and the fraction-bit mask. f_amt is only meaningful for
   // the FRAC class (1..MAN_W); the round bit is the top fraction bit, the
   // sticky bits are the ones below it, and the kept LSB sits just above.
   always_comb begin
      sign      = data_i[W];
      exp_f     = data_i[W-1:MAN_W];
      man       = data_i[MAN_W-1:0];
      mag       = data_i[W-1:0];
      mode      = round_mode_e'(mode_i);
      f_amt     = EXP_W'(MAN_W) - (exp_f - BIAS_E);
      mask      = ~({W{1'b1}} << f_amt);
      frac_nz   = |(mag & mask);
      round_bit = |(mag & (mask ^ (mask >> 1)));
      sticky    = |(mag & (mask >> 1));
      kept_lsb  = |(mag & (mask + W'(1)));
   end

   // Classification, ordered so specials and zeros win over range checks.
   always_comb begin
      cls = FRAC;
      if (exp_f == EXP_ONES) begin
         cls = SPECIAL;
      end else if (exp_f == '0) begin
         cls = ZERO;
      end else if (exp_f >= INT_E) begin
         cls = INTEGRAL;
      end else if (exp_f < BIAS_E) begin
         cls = SUB_ONE;
      end
   end

   // Increment decision. For SUB_ONE the kept value is zero, so an increment
   // means the result becomes +/-1.0; only 0.5 < |a| < 1 rounds up under RNE.
   always_comb begin
      inc_o   = 1'b0;
      mask_o  = '0;
      class_o = cls;
      case (cls)
         SUB_ONE: begin
            case (mode)
               FLOOR:   inc_o = sign;
               CEIL:    inc_o = ~sign;
               TRUNC:   inc_o = 1'b0;
               RNE:     inc_o = (exp_f == HALF_E) && (man != '0);
               default: inc_o = 1'b0;
            endcase
         end
         FRAC: begin
            mask_o = mask;
            case (mode)
               FLOOR:   inc_o = sign & frac_nz;
               CEIL:    inc_o = ~sign & frac_nz;
               TRUNC:   inc_o = 1'b0;
               RNE:     inc_o = round_bit & (sticky | kept_lsb);
               default: inc_o = 1'b0;
            endcase
         end
         default: inc_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_round_pipe.sv
// ---------------------------------------------------------------------------
// fp_round_pipe
// Two-stage pipelined float-to-integral rounding unit (floor, ceil, trunc,
// round-half-even) with valid/ready flow control on both sides.
// Ports:
//   core_clock_i / core_reset_i : clock, async active-high reset
//   in_valid_i / in_ready_o     : input handshake
//   in_data_i, in_mode_i        : operand {sign, exp, man} and rounding mode
//   in_tag_i                    : opaque tag travelling with the operation
//   out_valid_o / out_ready_i   : output handshake
//   out_data_o, out_tag_o       : rounded result and its tag
// ---------------------------------------------------------------------------
module fp_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 15,
   parameter int TAG_W = 6
) (
   input  logic                 core_clock_i,
   input  logic                 core_reset_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [EXP_W+MAN_W:0] in_data_i,
   input  logic [1:0]           in_mode_i,
   input  logic [TAG_W-1:0]     in_tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [EXP_W+MAN_W:0] out_data_o,
   output logic [TAG_W-1:0]     out_tag_o
);

   import fp_pkg::*;

   localparam int W = EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(fp_bias(EXP_W));
   localparam logic [W-1:0]     ONE_MAG = {BIAS_E, {MAN_W{1'b0}}};

   logic [2:0]   dec_class;
   logic [W-1:0] dec_mask;
   logic         dec_inc;

   logic adv2;
   logic load1;
   logic load2;
   logic in_ready;

   // Stage 1: class, fraction mask, increment decision, operand and tag
   logic         v1_q, v1_d;
   fp_class_e    class1_q, class1_d;
   logic [W-1:0] mask1_q, mask1_d;
   logic         inc1_q, inc1_d;
   logic [W:0]   data1_q, data1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d;

   // Stage 2: final result and tag
   logic         v2_q, v2_d;
   logic [W:0]   data2_q, data2_d;
   logic [TAG_W-1:0] tag2_q, tag2_d;

   logic [W:0]   result;
   logic [W-1:0] kept;

   fp_round_decode #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_decode (
      .data_i  (in_data_i),
      .mode_i  (in_mode_i),
      .class_o (dec_class),
      .mask_o  (dec_mask),
      .inc_o   (dec_inc)
   );

   // Stage handshakes: a stage may load when it is empty or is being drained
   // in the same cycle, so in_ready never depends on in_valid.
   always_comb begin
      adv2     = !v2_q || out_ready_i;
      load2    = v1_q && adv2;
      in_ready = !v1_q || adv2;
      load1    = in_valid_i && in_ready;
   end

   // Stage-2 result: clear the fraction bits and add one integral unit
   // (mask+1) when rounding away; the carry may ripple into the exponent.
   always_comb begin
      kept   = data1_q[W-1:0] & ~mask1_q;
      result = data1_q;
      case (class1_q)
         SPECIAL:  result = data1_q;
         INTEGRAL: result = data1_q;
         ZERO:     result = {data1_q[W], {W{1'b0}}};
         SUB_ONE:  result = {data1_q[W], (inc1_q ? ONE_MAG : {W{1'b0}})};
         FRAC:     result = {data1_q[W], kept + (inc1_q ? (mask1_q + W'(1)) : {W{1'b0}})};
         default:  result = data1_q;
      endcase
   end

   // Next-state for both stages; payloads hold unless their stage loads.
   always_comb begin
      v1_d     = load1 || (v1_q && !adv2);
      class1_d = load1 ? fp_class_e'(dec_class) : class1_q;
      mask1_d  = load1 ? dec_mask  : mask1_q;
      inc1_d   = load1 ? dec_inc   : inc1_q;
      data1_d  = load1 ? in_data_i : data1_q;
      tag1_d   = load1 ? in_tag_i  : tag1_q;
      v2_d     = load2 || (v2_q && !out_ready_i);
      data2_d  = load2 ? result    : data2_q;
      tag2_d   = load2 ? tag1_q    : tag2_q;
   end

   // Pipeline registers; reset drops everything in flight.
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         v1_q     <= 1'b0;
         class1_q <= ZERO;
         mask1_q  <= '0;
         inc1_q   <= 1'b0;
         data1_q  <= '0;
         tag1_q   <= '0;
         v2_q     <= 1'b0;
         data2_q  <= '0;
         tag2_q   <= '0;
      end else begin
         v1_q     <= v1_d;
         class1_q <= class1_d;
         mask1_q  <= mask1_d;
         inc1_q   <= inc1_d;
         data1_q  <= data1_d;
         tag1_q   <= tag1_d;
         v2_q     <= v2_d;
         data2_q  <= data2_d;
         tag2_q   <= tag2_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = v2_q;
   assign out_data_o  = data2_q;
   assign out_tag_o   = tag2_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_round_pipe
// Directed bench for fp_round_pipe with hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_fp_round_pipe;

   localparam logic [1:0] M_FLOOR = 2'b00;
   localparam logic [1:0] M_CEIL  = 2'b01;
   localparam logic [1:0] M_TRUNC = 2'b10;
   localparam logic [1:0] M_RNE   = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_data = '0;
   logic [1:0]  in_mode = '0;
   logic [5:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [23:0] out_data;
   logic [5:0]  out_tag;

   int vec_count = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fp_round_pipe dut (
      .core_clock_i (clk),
      .core_reset_i (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .in_mode_i    (in_mode),
      .in_tag_i     (in_tag),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .out_tag_o    (out_tag)
   );

   // Sends one operation into an empty pipe and waits (bounded) for its
   // result. lat counts rising edges from the accepting edge inclusive.
   task automatic run_op(input logic [23:0] d, input logic [1:0] m, input logic [5:0] t,
                         output logic [23:0] r, output logic [5:0] rt, output int lat);
      in_data   = d;
      in_mode   = m;
      in_tag    = t;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r  = out_data;
      rt = out_tag;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vec_count++;
      if (out_valid !== 1'b0 || out_data !== 24'h0 || out_tag !== 6'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got valid=%b data=%h tag=%h expected 0/000000/00",
                  out_valid, out_data, out_tag);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vec_count++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_floor();
      logic [23:0] d[2]  = '{24'h3FC000, 24'hBFC000};
      logic [23:0] ex[2] = '{24'h3F8000, 24'hC00000};
      logic [23:0] r;
      logic [5:0]  rt;
      int lat;
      for (int i = 0; i < 2; i++) begin
         run_op(d[i], M_FLOOR, 6'(i + 1), r, rt, lat);
         vec_count++;
         if (r !== ex[i] || rt !== 6'(i + 1)) begin
            miscompares++;
            $display("[TB] FAIL floor_%0d: got %h tag %h expected %h tag %h", i, r, rt, ex[i], 6'(i + 1));
         end
         vec_count++;
         if (lat !== 2) begin
            miscompares++;
            $display("[TB] FAIL floor_latency_%0d: got %0d expected 2", i, lat);
         end
      end
   endtask

   task automatic test_round();
      logic [23:0] d[2]  = '{24'h402000, 24'h406000};
      logic [23:0] ex[2] = '{24'h400000, 24'h408000};
      logic [23:0] r;
      logic [5:0]  rt;
      int lat;
      for (int i = 0; i < 2; i++) begin
         run_op(d[i], M_RNE, 6'(i + 5), r, rt, lat);
         vec_count++;
         if (r !== ex[i]) begin
            miscompares++;
            $display("[TB] FAIL round_%0d: got %h expected %h", i, r, ex[i]);
         end
      end
   endtask

   task automatic test_sub_one();
      logic [23:0] ex[4] = '{24'hBF8000, 24'h800000, 24'h800000, 24'h800000};
      logic [23:0] r;
      logic [5:0]  rt;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(24'hBE8000, 2'(i), 6'(i + 20), r, rt, lat);
         vec_count++;
         if (r !== ex[i]) begin
            miscompares++;
            $display("[TB] FAIL neg_quarter_mode%0d: got %h expected %h", i, r, ex[i]);
         end
      end
   endtask

   task automatic test_passthrough();
      logic [23:0] d[4]  = '{24'h7F8000, 24'h7FC001, 24'h498000, 24'h800001};
      logic [1:0]  m[4]  = '{M_CEIL, M_RNE, M_FLOOR, M_FLOOR};
      logic [23:0] ex[4] = '{24'h7F8000, 24'h7FC001, 24'h498000, 24'h800000};
      logic [23:0] r;
      logic [5:0]  rt;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(d[i], m[i], 6'(i + 30), r, rt, lat);
         vec_count++;
         if (r !== ex[i]) begin
            miscompares++;
            $display("[TB] FAIL passthru_%0d: got %h expected %h", i, r, ex[i]);
         end
      end
   endtask

   // Edges of the fractional range and ties: one fraction bit, exact 0.5,
   // just-below-one, mantissa overflow, already-integral 1.0, -0, max finite.
   task automatic test_boundary();
      logic [23:0] d[9]  = '{24'h468001, 24'h468001, 24'h3FF000, 24'h3FC000, 24'h3F0000,
                             24'hBF4000, 24'h3F8000, 24'h800000, 24'h7F7FFF};
      logic [1:0]  m[9]  = '{M_RNE, M_CEIL, M_CEIL, M_RNE, M_RNE,
                             M_RNE, M_FLOOR, M_CEIL, M_CEIL};
      logic [23:0] ex[9] = '{24'h468000, 24'h468002, 24'h400000, 24'h400000, 24'h000000,
                             24'hBF8000, 24'h3F8000, 24'h800000, 24'h7F7FFF};
      logic [23:0] r;
      logic [5:0]  rt;
      int lat;
      for (int i = 0; i < 9; i++) begin
         run_op(d[i], m[i], 6'(i + 40), r, rt, lat);
         vec_count++;
         if (r !== ex[i]) begin
            miscompares++;
            $display("[TB] FAIL boundary_%0d: got %h expected %h", i, r, ex[i]);
         end
      end
   endtask

   // Streams 8 operations while out_ready follows 1,0,0,1. Each cycle the
   // visible result must be the next expected one (so it is held while
   // stalled), and in_ready may drop only with two items held and a stall.
   task automatic test_back_to_back();
      logic [23:0] d[8]  = '{24'h3FC000, 24'hBFC000, 24'h402000, 24'h406000,
                             24'h401000, 24'hC03000, 24'h3FF000, 24'h7FC001};
      logic [1:0]  m[8]  = '{M_FLOOR, M_FLOOR, M_RNE, M_RNE, M_CEIL, M_TRUNC, M_CEIL, M_RNE};
      logic [23:0] ex[8] = '{24'h3F8000, 24'hC00000, 24'h400000, 24'h408000,
                             24'h404000, 24'hC00000, 24'h400000, 24'h7FC001};
      logic        rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic        exp_rdy;
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      while (recv < 8 && cyc < 200) begin
         @(posedge clk);
         #1;
         out_ready = rdy_pat[cyc % 4];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_data = d[sent];
            in_mode = m[sent];
            in_tag  = 6'(sent + 10);
         end
         @(negedge clk);
         exp_rdy = !((sent - recv) == 2 && !out_ready);
         vec_count++;
         if (in_ready !== exp_rdy) begin
            miscompares++;
            $display("[TB] FAIL b2b_in_ready_cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy);
         end
         if (out_valid) begin
            vec_count++;
            if (recv >= 8) begin
               miscompares++;
               $display("[TB] FAIL b2b_extra: got result %h expected none", out_data);
            end else if (out_data !== ex[recv] || out_tag !== 6'(recv + 10)) begin
               miscompares++;
               $display("[TB] FAIL b2b_result_%0d: got %h tag %h expected %h tag %h",
                        recv, out_data, out_tag, ex[recv], 6'(recv + 10));
            end
            if (out_ready) recv++;
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      vec_count++;
      if (recv !== 8) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %0d results expected 8", recv);
      end
   endtask

   task automatic test_reset_midflight();
      logic [23:0] r;
      logic [5:0]  rt;
      int lat;
      int seen = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 24'h3FC000;
      in_mode   = M_FLOOR;
      in_tag    = 6'd50;
      @(posedge clk);
      #1;
      in_data = 24'h402000;
      in_tag  = 6'd51;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      vec_count++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midflight_loaded: got valid=%b expected 1", out_valid);
      end
      rst = 1'b1;
      #1;
      vec_count++;
      if (out_valid !== 1'b0 || out_data !== 24'h0 || out_tag !== 6'h0) begin
         miscompares++;
         $display("[TB] FAIL midflight_reset: got valid=%b data=%h tag=%h expected 0/000000/00",
                  out_valid, out_data, out_tag);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      vec_count++;
      if (seen !== 0) begin
         miscompares++;
         $display("[TB] FAIL midflight_ghost: got %0d results expected 0", seen);
      end
      run_op(24'h406000, M_RNE, 6'd52, r, rt, lat);
      vec_count++;
      if (r !== 24'h408000 || rt !== 6'd52 || lat !== 2) begin
         miscompares++;
         $display("[TB] FAIL midflight_next: got %h tag %h lat %0d expected 408000 tag 34 lat 2",
                  r, rt, lat);
      end
   endtask

   initial begin
      test_reset();
      test_floor();
      test_round();
      test_sub_one();
      test_passthrough();
      test_boundary();
      test_back_to_back();
      test_reset_midflight();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

   // Hard stop in case a wait above ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
